// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
// Optional auto-sequencing build is selected with DEMUX_AUTO_SEQ_EN.
package demux_pkg;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned CH_W       = 2;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [CH_W-1:0] ch_t;

endpackage

// File: rtl/demux_ch_fifo2.sv
// Two-entry per-channel word buffer with head-of-queue output.
// A push while full or a pop while empty is ignored.
module demux_ch_fifo2
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/demux_1_4_seq.sv
// Registered 1-to-4 demux: steers accepted words into four 2-deep FIFOs.
// Define DEMUX_AUTO_SEQ_EN to steer by an internal round-robin pointer.
module demux_1_4_seq
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_W-1:0]     d_in,
  input  logic                  valid_in,
  input  logic [1:0]            sel_in,
  output logic                  ready_out,
  output logic [4*DATA_W-1:0]   y_out,
  output logic [3:0]            y_valid_out,
  input  logic [3:0]            y_ready_in,
  output logic [1:0]            ch_out,
  output logic [4*CNT_W-1:0]    cnt_out
`ifdef DEMUX_AUTO_SEQ_EN
  ,
  input  logic                  frame_in
`endif
);

  ch_t              t;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic             accept;
  logic [CNT_W-1:0] cnt_q [NUM_CH];

`ifdef DEMUX_AUTO_SEQ_EN
  ch_t  ptr_q;
  logic unused_sel;

  assign unused_sel = ^sel_in;
  // frame_in realigns this very push to channel 0
  assign t = frame_in ? '0 : ptr_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      ptr_q <= '0;
    else if (accept)
      ptr_q <= ch_t'(t + 1'b1);
    else if (frame_in)
      ptr_q <= '0;
  end
`else
  assign t = sel_in;
`endif

  assign ch_out      = t;
  assign ready_out   = ~full[t];
  assign accept      = valid_in & ready_out;
  assign y_valid_out = ~empty;
  assign pop         = y_ready_in & ~empty;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k] = accept & (t == ch_t'(k));

    demux_ch_fifo2 #(.DATA_W(DATA_W)) u_fifo (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (d_in),
      .dout  (y_out[k*DATA_W +: DATA_W]),
      .full  (full[k]),
      .empty (empty[k])
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
        cnt_q[k] <= '0;
      else if (push[k])
        cnt_q[k] <= cnt_q[k] + 1'b1;
    end

    assign cnt_out[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule

// File: tb/tb_demux_1_4_seq.sv
// Self-checking bench for demux_1_4_seq against a queue-based model.
// Covers reset, steering, backpressure, push+pop, counter wrap, random traffic.
module tb_demux_1_4_seq;

  logic        clk_in;
  logic        rst_n_in;
  logic [7:0]  d_in;
  logic        valid_in;
  logic [1:0]  sel_in;
  logic        ready_out;
  logic [31:0] y_out;
  logic [3:0]  y_valid_out;
  logic [3:0]  y_ready_in;
  logic [1:0]  ch_out;
  logic [63:0] cnt_out;
  logic        frame_in;

  int checks;
  int errors;

  logic [7:0]  mq [4][$];
  logic [15:0] mcnt [4];
  int          mptr;

  demux_1_4_seq dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .d_in        (d_in),
    .valid_in    (valid_in),
    .sel_in      (sel_in),
    .ready_out   (ready_out),
    .y_out       (y_out),
    .y_valid_out (y_valid_out),
    .y_ready_in  (y_ready_in),
    .ch_out      (ch_out),
    .cnt_out     (cnt_out)
`ifdef DEMUX_AUTO_SEQ_EN
    ,
    .frame_in    (frame_in)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] lane(input int k);
    return y_out[k*8 +: 8];
  endfunction

  function automatic logic [15:0] cnt_lane(input int k);
    return cnt_out[k*16 +: 16];
  endfunction

  function automatic int target();
`ifdef DEMUX_AUTO_SEQ_EN
    return frame_in ? 0 : mptr;
`else
    return int'(sel_in);
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcnt[k] = '0;
    end
    mptr = 0;
  endtask

  // advance one clock and apply the transfer rules to the model
  task automatic tick();
    int  t;
    bit  acc;
    bit  pp [4];
    t   = target();
    acc = valid_in && (mq[t].size() < 2);
    for (int k = 0; k < 4; k++)
      pp[k] = y_ready_in[k] && (mq[k].size() > 0);
    @(posedge clk_in);
    for (int k = 0; k < 4; k++)
      if (pp[k]) void'(mq[k].pop_front());
    if (acc) begin
      mq[t].push_back(d_in);
      mcnt[t] = mcnt[t] + 16'd1;
      mptr = (t + 1) % 4;
    end else if (frame_in) begin
      mptr = 0;
    end
    #1;
  endtask

  task automatic drain();
    valid_in   = 1'b0;
    frame_in   = 1'b0;
    y_ready_in = 4'hF;
    tick();
    tick();
    y_ready_in = 4'h0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    model_clear();
    checks++;
    if (y_valid_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_valid: got %h expected 0", y_valid_out);
    end
    checks++;
    if (cnt_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h expected 0", cnt_out);
    end
    checks++;
    if (y_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_y: got %h expected 0", y_out);
    end
    checks++;
    if (ch_out !== 2'd0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ch_ready: got ch=%0d rdy=%b expected ch=0 rdy=1",
               ch_out, ready_out);
    end
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_steering();
    y_ready_in = 4'h0;
    valid_in   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel_in = 2'(k);
      d_in   = 8'hA0 + 8'(k);
      tick();
    end
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (y_valid_out[k] !== 1'b1 || lane(k) !== 8'hA0 + 8'(k)) begin
        errors++;
        $display("FAIL steer_lane%0d: got v=%b d=%h expected v=1 d=%h",
                 k, y_valid_out[k], lane(k), 8'hA0 + 8'(k));
      end
      checks++;
      if (cnt_lane(k) !== mcnt[k]) begin
        errors++;
        $display("FAIL steer_cnt%0d: got %h expected %h", k, cnt_lane(k), mcnt[k]);
      end
    end
    drain();
    checks++;
    if (y_valid_out !== 4'h0) begin
      errors++;
      $display("FAIL steer_drain: got %h expected 0", y_valid_out);
    end
  endtask

  task automatic test_full();
    logic [7:0] got [$];
    logic [7:0] exp [3];
    bit acc;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    y_ready_in = 4'h0;
    valid_in   = 1'b1;
    sel_in     = 2'd2;
    d_in = 8'h11; tick();
    d_in = 8'h22; tick();
    d_in = 8'h33;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b expected 0", ready_out);
    end
    tick();
    checks++;
    if (lane(2) !== 8'h11 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: got d=%h rdy=%b expected d=11 rdy=0",
               lane(2), ready_out);
    end
    y_ready_in[2] = 1'b1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (y_valid_out[2]) got.push_back(lane(2));
      acc = valid_in && (mq[2].size() < 2);
      tick();
      if (acc) valid_in = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL full_order_len: got %0d expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL full_order%0d: got %h expected %h", i, got[i], exp[i]);
        end
      end
    end
    valid_in = 1'b0;
    drain();
  endtask

  task automatic test_simul();
    y_ready_in = 4'h0;
    valid_in   = 1'b1;
    sel_in     = 2'd3;
    d_in = 8'h55; tick();
    d_in = 8'h66;
    y_ready_in[3] = 1'b1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready: got %b expected 1", ready_out);
    end
    tick();
    y_ready_in = 4'h0;
    valid_in   = 1'b0;
    checks++;
    if (y_valid_out[3] !== 1'b1 || lane(3) !== 8'h66) begin
      errors++;
      $display("FAIL simul_head: got v=%b d=%h expected v=1 d=66",
               y_valid_out[3], lane(3));
    end
    valid_in = 1'b1;
    d_in = 8'h77; tick();
    valid_in = 1'b0;
    checks++;
    if (ready_out !== 1'b0 || mq[3].size() != 2) begin
      errors++;
      $display("FAIL simul_occ: got rdy=%b expected 0 (model occ %0d)",
               ready_out, mq[3].size());
    end
    drain();
  endtask

  task automatic test_wrap();
    y_ready_in = 4'b0001;
    valid_in   = 1'b1;
    sel_in     = 2'd0;
    for (int i = 0; i < 70000 && mcnt[0] != 16'hFFFF; i++) begin
      d_in = 8'($urandom);
      tick();
    end
    checks++;
    if (cnt_lane(0) !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre: got %h expected ffff", cnt_lane(0));
    end
    tick();
    checks++;
    if (cnt_lane(0) !== mcnt[0] || mcnt[0] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_post: got %h expected 0000", cnt_lane(0));
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_in   = 1'($urandom);
      sel_in     = 2'($urandom);
      d_in       = 8'($urandom);
      y_ready_in = 4'($urandom);
      frame_in   = ($urandom_range(0, 9) == 0);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (y_valid_out[k] !== (mq[k].size() > 0)) begin
          errors++;
          $display("FAIL rand_valid%0d: got %b expected %b",
                   k, y_valid_out[k], mq[k].size() > 0);
        end else if (mq[k].size() > 0 && lane(k) !== mq[k][0]) begin
          errors++;
          $display("FAIL rand_data%0d: got %h expected %h", k, lane(k), mq[k][0]);
        end
        checks++;
        if (cnt_lane(k) !== mcnt[k]) begin
          errors++;
          $display("FAIL rand_cnt%0d: got %h expected %h", k, cnt_lane(k), mcnt[k]);
        end
      end
      checks++;
      if (ch_out !== 2'(target()) ||
          ready_out !== (mq[target()].size() < 2)) begin
        errors++;
        $display("FAIL rand_ctl: got ch=%0d rdy=%b expected ch=%0d rdy=%b",
                 ch_out, ready_out, target(), mq[target()].size() < 2);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_auto_seq();
    y_ready_in = 4'h0;
    frame_in   = 1'b0;
    valid_in   = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      d_in = 8'(i);
      tick();
    end
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (y_valid_out[k] !== (mq[k].size() > 0) ||
          (mq[k].size() > 0 && lane(k) !== mq[k][0])) begin
        errors++;
        $display("FAIL auto_head%0d: got %h expected %h", k, lane(k), 8'(k + 1));
      end
    end
    checks++;
    if (mq[0].size() != 2 || mq[0][1] !== 8'd5 ||
        mq[1].size() != 2 || mq[1][1] !== 8'd6 || cnt_lane(0) !== mcnt[0]) begin
      errors++;
      $display("FAIL auto_wrap: got cnt0=%h expected %h", cnt_lane(0), mcnt[0]);
    end
    drain();
    valid_in = 1'b1;
    frame_in = 1'b1;
    d_in     = 8'd7;
    checks++;
    if (ch_out !== 2'd0) begin
      errors++;
      $display("FAIL auto_frame_ch: got %0d expected 0", ch_out);
    end
    tick();
    valid_in = 1'b0;
    frame_in = 1'b0;
    checks++;
    if (ch_out !== 2'd1 || y_valid_out[0] !== 1'b1 || lane(0) !== 8'd7) begin
      errors++;
      $display("FAIL auto_frame: got ch=%0d d0=%h expected ch=1 d0=07",
               ch_out, lane(0));
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    y_ready_in = 4'h0;
    valid_in   = 1'b1;
    sel_in     = 2'd1;
    d_in = 8'hC1; tick();
    d_in = 8'hC2; tick();
    valid_in = 1'b0;
    checks++;
    if (y_valid_out[1] !== 1'b1 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: got v=%b rdy=%b expected v=1 rdy=0",
               y_valid_out[1], ready_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    model_clear();
    checks++;
    if (y_valid_out !== 4'h0 || cnt_out !== 64'h0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rstmid: got v=%h cnt=%h rdy=%b expected v=0 cnt=0 rdy=1",
               y_valid_out, cnt_out, ready_out);
    end
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    d_in       = '0;
    valid_in   = 1'b0;
    sel_in     = '0;
    y_ready_in = '0;
    frame_in   = 1'b0;
    model_clear();
    test_reset();
`ifdef DEMUX_AUTO_SEQ_EN
    test_auto_seq();
`else
    test_steering();
    test_full();
    test_simul();
    test_wrap();
`endif
    test_random();
`ifndef DEMUX_AUTO_SEQ_EN
    test_reset_midstream();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
